// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-controller arbiter: FSM state encoding
// and the default SPI wait-cycle timeout.
package mem_ctrl_pkg;

    localparam int DEF_SPI_TMO = 1023;

    typedef enum logic [2:0] {
        IDLE,
        INT_WR,
        INT_RD,
        INT_WAIT,
        INT_CAP,
        SPI_REQ,
        SPI_WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mem_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant searching from the channel after
// the last granted one; the pointer only moves when the grant is taken.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_update,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic [IDX_W-1:0]  r_last;
    int                w_cand;
    logic [NUM_CH-1:0] w_sh;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        w_sh    = '0;
        for (int off = NUM_CH; off >= 1; off--) begin
            w_cand = (int'(r_last) + off) % NUM_CH;
            w_sh   = i_req >> w_cand;
            if (w_sh[0]) begin
                o_grant = NUM_CH'(1) << w_cand;
                o_idx   = IDX_W'(w_cand);
                o_any   = 1'b1;
            end
        end
    end

    // Pointer starts at the last channel so channel 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= IDX_W'(NUM_CH - 1);
        end else if (i_update) begin
            r_last <= o_idx;
        end
    end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Multi-channel memory request arbiter. Accepts one request at a time in
// round-robin order and routes it to the internal RAM (low addresses) or to
// the SPI device (everything else), with a timeout on the SPI handshake.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 8,
    parameter int INT_AW  = 8,
    parameter int SPI_TMO = DEF_SPI_TMO
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     err,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic                     ram_we,
    output logic                     ram_re,
    output logic [INT_AW-1:0]        ram_addr,
    output logic [DATA_W-1:0]        ram_din,
    input  logic [DATA_W-1:0]        ram_dout,
    output logic                     spi_we,
    output logic                     spi_re,
    output logic [ADDR_W-1:0]        spi_addr,
    output logic [DATA_W-1:0]        spi_din,
    input  logic [DATA_W-1:0]        spi_dout,
    input  logic                     spi_done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(SPI_TMO + 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_err_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_CH-1:0]  r_ack;
    logic [NUM_CH-1:0]  r_done;
    logic               r_err;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_busy;

    logic [NUM_CH-1:0]  w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any;
    logic               w_accept;
    logic [ADDR_W-1:0]  w_gaddr;
    logic               w_tmo;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (ch_req),
        .i_update (w_accept),
        .o_grant  (w_grant),
        .o_idx    (w_gidx),
        .o_any    (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;
    assign w_gaddr  = ch_addr[w_gidx*ADDR_W +: ADDR_W];
    assign w_tmo    = (r_cnt == CNT_W'(SPI_TMO));

    assign ch_ack   = r_ack;
    assign ch_done  = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign busy     = r_busy;
    assign ram_addr = r_addr[INT_AW-1:0];
    assign ram_din  = r_wdata;
    assign spi_addr = r_addr;
    assign spi_din  = r_wdata;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and single-cycle memory/SPI strobes.
    always_comb begin
        w_next = r_state;
        ram_we = 1'b0;
        ram_re = 1'b0;
        spi_we = 1'b0;
        spi_re = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if ((w_gaddr >> INT_AW) == '0) begin
                        w_next = ch_we[w_gidx] ? INT_WR : INT_RD;
                    end else begin
                        w_next = SPI_REQ;
                    end
                end
            end
            INT_WR: begin
                ram_we = 1'b1;
                w_next = DONE;
            end
            INT_RD: begin
                ram_re = 1'b1;
                w_next = INT_WAIT;
            end
            INT_WAIT: w_next = INT_CAP;
            INT_CAP:  w_next = DONE;
            SPI_REQ: begin
                spi_we = r_we;
                spi_re = ~r_we;
                w_next = SPI_WAIT;
            end
            SPI_WAIT: begin
                if (spi_done || w_tmo) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request latching, read capture, timeout counting and the
    // registered ack/done/err pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err_pend <= 1'b0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_idx      <= w_gidx;
                r_we       <= ch_we[w_gidx];
                r_addr     <= w_gaddr;
                r_wdata    <= ch_wdata[w_gidx*DATA_W +: DATA_W];
                r_ack      <= w_grant;
                r_busy     <= 1'b1;
                r_err_pend <= 1'b0;
            end
            case (r_state)
                INT_CAP: r_rdata <= ram_dout;
                SPI_REQ: r_cnt <= '0;
                SPI_WAIT: begin
                    // A completion arriving on the timeout cycle still counts.
                    if (spi_done) begin
                        if (!r_we) begin
                            r_rdata <= spi_dout;
                        end
                        r_err_pend <= 1'b0;
                    end else if (w_tmo) begin
                        r_err_pend <= 1'b1;
                        r_rdata    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done <= NUM_CH'(1) << r_idx;
                    r_err  <= r_err_pend;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
